// File: rtl/tqvp_apu_pkg.sv
// Shared constants, types and helpers for the TinyQV 2A03-style pulse channel.
package tqvp_apu_pkg;

    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned PERIOD_W = 11;
    localparam int unsigned LEN_W    = 8;
    localparam int unsigned PRESC_W  = 16;
    localparam int unsigned STEP_W   = 3;
    localparam int unsigned VOL_W    = 4;
    localparam int unsigned DUTY_W   = 2;

    // Register map
    localparam logic [ADDR_W-1:0] ADDR_CTRL     = 6'h00;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD   = 6'h04;
    localparam logic [ADDR_W-1:0] ADDR_LENGTH   = 6'h08;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 6'h0C;
    localparam logic [ADDR_W-1:0] ADDR_PRESCALE = 6'h10;

    // Periods below this are ultrasonic on the real part and are silenced.
    localparam logic [PERIOD_W-1:0] MUTE_PERIOD = 11'd8;

    localparam logic [PRESC_W-1:0] PRESC_RESET = 16'hFFFF;

    // Duty sequences; leftmost bit is step 0.
    localparam logic [3:0][7:0] DUTY_TABLE = {
        8'b10011111,    // duty 3
        8'b01111000,    // duty 2
        8'b01100000,    // duty 1
        8'b01000000     // duty 0
    };

    // Bus write size encoding on data_write_n / data_read_n.
    typedef enum logic [1:0] {
        WR_8    = 2'b00,
        WR_16   = 2'b01,
        WR_32   = 2'b10,
        WR_NONE = 2'b11
    } wr_size_e;

    // CTRL register layout.
    typedef struct packed {
        logic [VOL_W-1:0]  volume;
        logic              enable;
        logic              halt;
        logic [DUTY_W-1:0] duty;
    } ctrl_t;

    // Select the duty bit for a given sequencer step (step 0 = MSB of the row).
    function automatic logic duty_lookup(input logic [DUTY_W-1:0] duty,
                                         input logic [STEP_W-1:0] step);
        logic [7:0] row;
        row = DUTY_TABLE[duty];
        return row[3'd7 - step];
    endfunction

endpackage

// File: rtl/tqvp_apu_pulse_timer.sv
// Half-rate period timer and 8-step duty sequencer for one pulse channel.
module tqvp_apu_pulse_timer
    import tqvp_apu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic [DUTY_W-1:0]   duty,
    input  logic                restart,
    output logic                duty_bit
);

    logic                half;
    logic [PERIOD_W-1:0] timer;
    logic [STEP_W-1:0]   step;

    // APU clock divider: the timer only acts on every other clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half <= 1'b0;
        end else begin
            half <= ~half;
        end
    end

    // Period down-counter and step sequencer; restart realigns both to a note start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
            step  <= '0;
        end else if (restart) begin
            timer <= period;
            step  <= '0;
        end else if (half) begin
            if (timer == '0) begin
                timer <= period;
                step  <= step + 3'd1;
            end else begin
                timer <= timer - 11'd1;
            end
        end
    end

    assign duty_bit = duty_lookup(duty, step);

endmodule

// File: rtl/tqvp_apu_pulse.sv
// TinyQV peripheral: one 2A03-style pulse channel with length counter and expiry IRQ.
module tqvp_apu_pulse
    import tqvp_apu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        ui_in,
    output logic [7:0]        uo_out,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        data_write_n,
    input  logic [1:0]        data_read_n,
    output logic [DATA_W-1:0] data_out,
    output logic              data_ready,
    output logic              user_interrupt
);

    ctrl_t               ctrl;
    logic [PERIOD_W-1:0] period;
    logic [LEN_W-1:0]    length;
    logic [PRESC_W-1:0]  prescale;
    logic [PRESC_W-1:0]  presc_cnt;
    logic                irq;
    logic [7:0]          out_q;

    logic wr_any;
    logic wr_lane1;
    logic wr_ctrl;
    logic wr_period;
    logic wr_length;
    logic wr_status;
    logic wr_prescale;
    logic len_tick;
    logic len_expire;
    logic irq_clear;
    logic duty_bit;
    logic mute;
    logic pulse;

    // Write strobes and byte-lane qualification.
    assign wr_any      = (data_write_n != WR_NONE);
    assign wr_lane1    = (data_write_n == WR_16) || (data_write_n == WR_32);
    assign wr_ctrl     = wr_any && (address == ADDR_CTRL);
    assign wr_period   = wr_any && (address == ADDR_PERIOD);
    assign wr_length   = wr_any && (address == ADDR_LENGTH);
    assign wr_status   = wr_any && (address == ADDR_STATUS);
    assign wr_prescale = wr_any && (address == ADDR_PRESCALE);

    // Control, period and prescale registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl     <= '0;
            period   <= '0;
            prescale <= PRESC_RESET;
        end else begin
            if (wr_ctrl) begin
                ctrl <= ctrl_t'(data_in[7:0]);
            end
            if (wr_period) begin
                period[7:0] <= data_in[7:0];
                if (wr_lane1) begin
                    period[PERIOD_W-1:8] <= data_in[PERIOD_W-1:8];
                end
            end
            if (wr_prescale) begin
                prescale[7:0] <= data_in[7:0];
                if (wr_lane1) begin
                    prescale[PRESC_W-1:8] <= data_in[PRESC_W-1:8];
                end
            end
        end
    end

    assign len_tick = (presc_cnt == prescale);

    // Length-clock prescaler; a PRESCALE write restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (wr_prescale || len_tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 16'd1;
        end
    end

    // Only a tick-driven 1->0 decrement raises the IRQ, never a LENGTH write.
    assign len_expire = len_tick && !ctrl.halt && !wr_length && (length == 8'd1);

    // Length counter; a LENGTH write overrides a coincident tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            length <= '0;
        end else if (wr_length) begin
            length <= data_in[LEN_W-1:0];
        end else if (len_tick && !ctrl.halt && (length != '0)) begin
            length <= length - 8'd1;
        end
    end

    assign irq_clear = wr_status && data_in[1];

    // IRQ pending flag; a new expiry beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else if (len_expire) begin
            irq <= 1'b1;
        end else if (irq_clear) begin
            irq <= 1'b0;
        end
    end

    tqvp_apu_pulse_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .period   (period),
        .duty     (ctrl.duty),
        .restart  (wr_length),
        .duty_bit (duty_bit)
    );

    assign mute  = !ctrl.enable || (length == '0) || (period < MUTE_PERIOD);
    assign pulse = duty_bit && !mute;

    // Registered PMOD output: sample, raw pulse bit, unused low bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= {(pulse ? ctrl.volume : 4'h0), pulse, 3'b000};
        end
    end

    assign uo_out         = out_q;
    assign user_interrupt = irq;
    assign data_ready     = 1'b1;

    // Zero-wait-state register readback.
    always_comb begin
        data_out = '0;
        case (address)
            ADDR_CTRL:     data_out = 32'(ctrl);
            ADDR_PERIOD:   data_out = 32'(period);
            ADDR_LENGTH:   data_out = 32'(length);
            ADDR_STATUS:   data_out = 32'({irq, (length != '0)});
            ADDR_PRESCALE: data_out = 32'(prescale);
            default:       data_out = '0;
        endcase
    end

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ui_in, data_read_n, data_in[DATA_W-1:PRESC_W]};

endmodule

// File: tb/tb_tqvp_apu_pulse.sv
// Directed self-checking bench for the pulse-channel peripheral.
module tb_tqvp_apu_pulse;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ui_in;
    logic [7:0]  uo_out;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;

    int checks = 0;
    int passes = 0;

    localparam logic [5:0] A_CTRL = 6'h00;
    localparam logic [5:0] A_PER  = 6'h04;
    localparam logic [5:0] A_LEN  = 6'h08;
    localparam logic [5:0] A_STAT = 6'h0C;
    localparam logic [5:0] A_PRE  = 6'h10;

    always #5 clk = ~clk;

    tqvp_apu_pulse dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ui_in          (ui_in),
        .uo_out         (uo_out),
        .address        (address),
        .data_in        (data_in),
        .data_write_n   (data_write_n),
        .data_read_n    (data_read_n),
        .data_out       (data_out),
        .data_ready     (data_ready),
        .user_interrupt (user_interrupt)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
        address      = a;
        data_in      = d;
        data_write_n = sz;
        step(1);
        data_write_n = 2'b11;
        data_in      = '0;
    endtask

    task automatic rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(tag, data_out, exp);
    endtask

    // Count cycles where uo_out is nonzero over a window.
    task automatic count_nonzero(input int n, output int bad);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (uo_out != 8'h00) bad++;
            step(1);
        end
    endtask

    // Advance until uo_out is nonzero, at most n cycles.
    task automatic wait_sound(input int n);
        for (int i = 0; i < n; i++) begin
            if (uo_out != 8'h00) break;
            step(1);
        end
    endtask

    initial begin
        int hi, lo, hi2, bad;
        rst_n        = 1'b0;
        ui_in        = '0;
        address      = '0;
        data_in      = '0;
        data_write_n = 2'b11;
        data_read_n  = 2'b11;

        // Reset state
        step(3);
        check("rst_uo_out", 32'(uo_out), 32'h00);
        check("rst_irq", 32'(user_interrupt), 32'h0);
        check("rst_ready", 32'(data_ready), 32'h1);
        rd("rst_prescale", A_PRE, 32'h0000_FFFF);
        rd("rst_ctrl", A_CTRL, 32'h0);
        rd("rst_period", A_PER, 32'h0);
        rd("rst_length", A_LEN, 32'h0);
        rst_n = 1'b1;
        step(4);
        check("post_rst_uo_out", 32'(uo_out), 32'h00);

        // Waveform: duty 1, volume 15, P = 8 -> 36 high / 108 low
        wr(A_CTRL, 32'hF9, 2'b00);
        wr(A_PER, 32'h8, 2'b01);
        wr(A_PRE, 32'hFFFF, 2'b01);
        wr(A_LEN, 32'hFF, 2'b00);
        wait_sound(300);
        check("wave_level", 32'(uo_out), 32'hF8);
        hi = 0;
        while (uo_out[7:4] == 4'hF && hi < 400) begin hi++; step(1); end
        lo = 0;
        while (uo_out[7:4] == 4'h0 && lo < 400) begin lo++; step(1); end
        hi2 = 0;
        while (uo_out[7:4] == 4'hF && hi2 < 400) begin hi2++; step(1); end
        check("wave_high", 32'(hi), 32'd36);
        check("wave_low", 32'(lo), 32'd108);
        check("wave_high2", 32'(hi2), 32'd36);

        // Mute by short period, then restore
        wr(A_PER, 32'h7, 2'b01);
        step(2);
        count_nonzero(200, bad);
        check("mute_p7", 32'(bad), 32'd0);
        wr(A_PER, 32'h8, 2'b01);
        wait_sound(300);
        check("unmute_p8", 32'(uo_out), 32'hF8);

        // Mute by enable = 0
        wr(A_CTRL, 32'hF1, 2'b00);
        step(2);
        count_nonzero(200, bad);
        check("mute_disabled", 32'(bad), 32'd0);
        wr(A_CTRL, 32'hF9, 2'b00);

        // Length expiry: PRESCALE = 3 -> ticks at write edge +4 and +8
        wr(A_PRE, 32'h3, 2'b01);
        wr(A_LEN, 32'h2, 2'b00);
        rd("exp_len_loaded", A_LEN, 32'h2);
        step(2);
        rd("exp_len_before_tick", A_LEN, 32'h2);
        step(1);
        rd("exp_len_first_tick", A_LEN, 32'h1);
        step(3);
        rd("exp_len_hold", A_LEN, 32'h1);
        check("exp_irq_early", 32'(user_interrupt), 32'h0);
        step(1);
        rd("exp_len_zero", A_LEN, 32'h0);
        check("exp_irq_set", 32'(user_interrupt), 32'h1);
        rd("exp_status", A_STAT, 32'h2);
        step(1);
        check("exp_muted", 32'(uo_out), 32'h00);
        wr(A_STAT, 32'h2, 2'b00);
        check("exp_irq_cleared", 32'(user_interrupt), 32'h0);

        // Halt holds the count; release counts down one per clk
        wr(A_CTRL, 32'hFD, 2'b00);
        wr(A_PRE, 32'h0, 2'b01);
        wr(A_LEN, 32'h5, 2'b00);
        step(20);
        rd("halt_hold", A_LEN, 32'h5);
        check("halt_no_irq", 32'(user_interrupt), 32'h0);
        wr(A_CTRL, 32'hF9, 2'b00);
        rd("halt_release_edge", A_LEN, 32'h5);
        step(4);
        rd("halt_count_1", A_LEN, 32'h1);
        step(1);
        rd("halt_count_0", A_LEN, 32'h0);
        check("halt_irq", 32'(user_interrupt), 32'h1);
        wr(A_STAT, 32'h2, 2'b00);
        check("halt_irq_clear", 32'(user_interrupt), 32'h0);

        // LENGTH write coinciding with a tick keeps the written value
        wr(A_LEN, 32'h40, 2'b00);
        rd("coll_len_a", A_LEN, 32'h40);
        wr(A_LEN, 32'h20, 2'b00);
        rd("coll_len_b", A_LEN, 32'h20);

        // IRQ set coinciding with a STATUS clear keeps the IRQ
        wr(A_LEN, 32'h1, 2'b00);
        check("coll_irq_pre", 32'(user_interrupt), 32'h0);
        wr(A_STAT, 32'h2, 2'b00);
        check("coll_irq_set_wins", 32'(user_interrupt), 32'h1);
        rd("coll_len_zero", A_LEN, 32'h0);

        // Reset mid-note with IRQ pending
        wr(A_PRE, 32'hFFFF, 2'b01);
        wr(A_LEN, 32'hFF, 2'b00);
        wait_sound(300);
        check("midnote_sound", 32'(uo_out), 32'hF8);
        check("midnote_irq", 32'(user_interrupt), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_rst_uo_out", 32'(uo_out), 32'h00);
        check("async_rst_irq", 32'(user_interrupt), 32'h0);
        rd("async_rst_len", A_LEN, 32'h0);
        rd("async_rst_ctrl", A_CTRL, 32'h0);
        step(2);
        rst_n = 1'b1;
        step(2);

        // Byte-lane rules and unmapped reads
        wr(A_PRE, 32'h1234_5678, 2'b00);
        rd("pre_8bit", A_PRE, 32'h0000_FF78);
        wr(A_PRE, 32'h1234_5678, 2'b01);
        rd("pre_16bit", A_PRE, 32'h0000_5678);
        wr(A_PER, 32'hFFFF_FFFF, 2'b10);
        rd("period_32bit", A_PER, 32'h0000_07FF);
        wr(A_PER, 32'h0000_0123, 2'b00);
        rd("period_8bit", A_PER, 32'h0000_0723);
        wr(6'h14, 32'hFFFF_FFFF, 2'b10);
        rd("unmapped_rd", 6'h14, 32'h0);
        rd("ctrl_after_unmapped", A_CTRL, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tqvp_apu_pulse.md
# tqvp_apu_pulse

TinyQV peripheral implementing one 2A03-style pulse (square-wave) channel. It sits directly downstream of the TinyQV peripheral bus: it decodes register writes from the core, runs the period timer, duty sequencer and length counter, and drives a 4-bit sample plus a raw pulse bit onto the output PMOD. It raises `user_interrupt` when the length counter expires, so firmware can retrigger notes.

## Interface
Parameters: none.

- `clk` input 1: project clock, nominally 64 MHz.
- `rst_n` input 1: reset, **asynchronous, active-low**.
- `ui_in` input 8: input PMOD. Unused; tied off in an unused-signal reduction.
- `uo_out` output 8: `[7:4]` sample, `[3]` pulse bit, `[2:0]` = 0.
- `address` input 6: register address within the peripheral.
- `data_in` input 32: write data.
- `data_write_n` input 2: 11 none, 00 8-bit, 01 16-bit, 10 32-bit.
- `data_read_n` input 2: same encoding. Unused for side effects.
- `data_out` output 32: read data, combinational from `address`.
- `data_ready` output 1: constant 1.
- `user_interrupt` output 1: length-expiry IRQ pending flag.

## Operation
Byte-lane write rule:
- Bits `[7:0]` are written on any write.
- Bits `[15:8]` are written on 16- or 32-bit writes.
- Bits `[31:16]` are written on 32-bit writes only.

Registers (all unlisted addresses read 0; writes to them are ignored):
- 0x00 CTRL, reset 0x00:
  - `[1:0]` duty.
  - `[2]` halt: freezes the length counter.
  - `[3]` enable.
  - `[7:4]` volume.
- 0x04 PERIOD, reset 0x000: `[10:0]` timer reload value P.
- 0x08 LENGTH, reset 0x00:
  - Write loads `[7:0]` into the length counter, resets the sequencer step to 0 and reloads the timer with P.
  - Read returns the live count.
- 0x0C STATUS:
  - Read: `[0]` = length ≠ 0, `[1]` = IRQ pending.
  - Write: 1 to `[1]` clears the IRQ.
- 0x10 PRESCALE, reset 0xFFFF: `[15:0]` value N; the length clock ticks once every N+1 clk.

APU half-rate:
- A 1-bit toggle `half` flips every clk.
- The timer acts only on clk edges where `half` = 1.

Timer:
- 11-bit down counter.
- At 0 it reloads P and advances the 3-bit step, wrapping 7→0.
- Otherwise it decrements.

Duty table, indexed by step 0..7:
- 0: 01000000
- 1: 01100000
- 2: 01111000
- 3: 10011111

Mute: the output is muted when `enable` = 0, or length = 0, or P < 8.

Output:
- pulse = duty bit AND NOT mute.
- sample = pulse ? volume : 0.

Prescaler and length counter:
- The prescaler counts 0..N. On reaching N it returns to 0 and emits a one-clk tick.
- On a tick, the length counter decrements if it is nonzero and halt = 0.
- A 1→0 decrement sets the IRQ. A LENGTH write of 0 does not set the IRQ.

Boundary and simultaneous events:
- LENGTH write and tick in the same cycle: the write wins.
- IRQ set and STATUS clear in the same cycle: the set wins.
- Writing PERIOD changes only the reload value; the current count finishes first.
- Writing PRESCALE resets the prescale counter to 0.
- Halt = 1 holds the count but does not mute.
- Asserting `rst_n` mid-note immediately clears all state. Outputs go to 0, and the IRQ goes to 0.

## Timing
- Reset values:
  - `uo_out` = 0x00.
  - `user_interrupt` = 0.
  - `data_ready` = 1.
  - `data_out` reflects reset register values.
- Reads have zero wait states; `data_out` is valid in the same cycle as `address`.
- Register writes take effect on the next clk edge.
- `uo_out` and `user_interrupt` are registered: one cycle after the state change.
- Step period is 2·(P+1) clk; full waveform period is 16·(P+1) clk.
- First step advance after a LENGTH write: 2·(P+1) clk, with ±1 clk depending on `half` phase.
- IRQ asserts one clk after the expiring tick.

## Structure
- Package `tqvp_apu_pkg` holds:
  - Register address constants (ADDR_CTRL … ADDR_PRESCALE).
  - The duty table as a 4×8 constant.
  - Widths: PERIOD_W = 11, LEN_W = 8, PRESC_W = 16.
  - The mute threshold of 8.
- Sub-module `tqvp_apu_pulse_timer` contains:
  - The half-rate toggle, 11-bit timer, 3-bit step and duty lookup.
  - Inputs: `clk`, `rst_n`, `period`, `duty`, `restart`.
  - Output: `duty_bit`.
- The top level holds the registers, prescaler, length counter, IRQ, mute and output logic.

## Test plan
- **Reset:** hold `rst_n` low, then release.
  - Expected: `uo_out` = 0, `user_interrupt` = 0, PRESCALE reads 0xFFFF, CTRL/PERIOD/LENGTH read 0.
- **Waveform:** CTRL = 0xF9 (vol 15, en, duty 1), PERIOD = 8, LENGTH = 0xFF, PRESCALE = 0xFFFF.
  - Expected: `uo_out[7:4]` = 0xF for 36 clk, then 0 for 108 clk; period 144 clk.
- **Mute:** PERIOD = 7, or `enable` = 0, with the same setup as above.
  - Expected: `uo_out` stays 0x00. PERIOD = 8 restores output.
- **Length expiry:** PRESCALE = 3, LENGTH = 2, halt = 0.
  - Expected: count reaches 0 after 8 clk and output mutes.
  - Expected: `user_interrupt` rises one clk later; STATUS reads 0x2.
  - STATUS write 0x2 clears the IRQ.
- **Halt:** halt = 1, LENGTH = 5, PRESCALE = 0.
  - Expected: LENGTH reads 5 indefinitely.
  - Clearing halt: count reaches 0 in 5 clk.
- **Collisions:**
  - LENGTH write coinciding with a tick: the written value is retained.
  - IRQ set coinciding with a STATUS clear: the IRQ stays 1.
  - 8-bit write 0x12345678 to PRESCALE: reads 0xFF78.
